// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the serial parity link
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with clear-over-increment priority
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins, but a same-cycle increment still lands as a count of one.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - deserialise framed bits, check parity, count errors
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic                 frame_start,
    input  logic                 clear_cnt,
    output logic [DATA_W-1:0]    data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int   IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic ODD_BIT = (ODD_PARITY == PARITY_ODD) ? 1'b1 : 1'b0;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               acc_q, acc_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               perr_q, perr_d;
    logic               abort_q, abort_d;
    logic               err_inc;

    // Frame FSM: a qualified frame_start always restarts at bit 0, aborting any frame in flight.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        data_d  = data_q;
        perr_d  = perr_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        err_inc = 1'b0;
        if (sin_valid) begin
            if (frame_start) begin
                abort_d = (state_q != IDLE);
                shift_d = {{(DATA_W-1){1'b0}}, sin};
                acc_d   = sin;
                idx_d   = IDX_W'(1);
                state_d = DATA;
            end else begin
                case (state_q)
                    DATA: begin
                        shift_d[idx_q] = sin;
                        acc_d          = acc_q ^ sin;
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            state_d = PARITY;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    PARITY: begin
                        data_d  = shift_q;
                        perr_d  = (acc_q ^ sin) != ODD_BIT;
                        err_inc = (acc_q ^ sin) != ODD_BIT;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            abort_q <= abort_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clear_cnt),
        .count (err_count)
    );

    assign data_out    = data_q;
    assign frame_done  = done_q;
    assign parity_err  = perr_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - randomized self-checking bench for serial_parity_checker
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic reset;
    logic sin, sin_valid, frame_start, clear_cnt;

    logic [7:0] data_e, data_o, data_w;
    logic       done_e, done_o, done_w;
    logic       perr_e, perr_o, perr_w;
    logic       abrt_e, abrt_o, abrt_w;
    logic [7:0] cnt_e, cnt_o;
    logic [1:0] cnt_w;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit         in_frame;
    bit         bq[$];
    bit         m_done, m_abort;
    logic [7:0] m_data;
    bit         m_perr[3];
    int         m_cnt[3];
    bit         m_odd[3] = '{1'b0, 1'b1, 1'b0};
    int         m_max[3] = '{255, 255, 3};

    always #5 clk = ~clk;

    serial_parity_checker u_even (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .clear_cnt(clear_cnt),
        .data_out(data_e), .frame_done(done_e), .parity_err(perr_e),
        .frame_abort(abrt_e), .err_count(cnt_e)
    );

    serial_parity_checker #(.ODD_PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .clear_cnt(clear_cnt),
        .data_out(data_o), .frame_done(done_o), .parity_err(perr_o),
        .frame_abort(abrt_o), .err_count(cnt_o)
    );

    serial_parity_checker #(.ERR_CNT_W(2)) u_w2 (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .clear_cnt(clear_cnt),
        .data_out(data_w), .frame_done(done_w), .parity_err(perr_w),
        .frame_abort(abrt_w), .err_count(cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("even.done",  32'(done_e), 32'(m_done));
        check("even.abort", 32'(abrt_e), 32'(m_abort));
        check("even.data",  32'(data_e), 32'(m_data));
        check("even.perr",  32'(perr_e), 32'(m_perr[0]));
        check("even.cnt",   32'(cnt_e),  32'(m_cnt[0]));
        check("odd.done",   32'(done_o), 32'(m_done));
        check("odd.abort",  32'(abrt_o), 32'(m_abort));
        check("odd.data",   32'(data_o), 32'(m_data));
        check("odd.perr",   32'(perr_o), 32'(m_perr[1]));
        check("odd.cnt",    32'(cnt_o),  32'(m_cnt[1]));
        check("w2.done",    32'(done_w), 32'(m_done));
        check("w2.abort",   32'(abrt_w), 32'(m_abort));
        check("w2.data",    32'(data_w), 32'(m_data));
        check("w2.perr",    32'(perr_w), 32'(m_perr[2]));
        check("w2.cnt",     32'(cnt_w),  32'(m_cnt[2]));
    endtask

    task automatic model_reset();
        in_frame = 0;
        bq.delete();
        m_done  = 0;
        m_abort = 0;
        m_data  = '0;
        for (int k = 0; k < 3; k++) begin
            m_perr[k] = 0;
            m_cnt[k]  = 0;
        end
    endtask

    // Frame-level model: collect bits in a queue, judge the whole frame on its parity bit.
    task automatic model_update(input logic v, input logic s, input logic fs, input logic clr);
        bit         inc[3];
        logic [7:0] word;
        bit         ones;
        m_done  = 0;
        m_abort = 0;
        for (int k = 0; k < 3; k++) inc[k] = 0;
        if (v) begin
            if (fs) begin
                if (in_frame) m_abort = 1;
                bq.delete();
                bq.push_back(s);
                in_frame = 1;
            end else if (in_frame) begin
                if (bq.size() == 8) begin
                    word = '0;
                    for (int i = 0; i < 8; i++) word[i] = bq[i];
                    ones = 0;
                    for (int i = 0; i < 8; i++) ones = ones ^ bq[i];
                    ones = ones ^ s;
                    m_done = 1;
                    m_data = word;
                    for (int k = 0; k < 3; k++) begin
                        m_perr[k] = (ones != m_odd[k]);
                        inc[k]    = m_perr[k];
                    end
                    in_frame = 0;
                    bq.delete();
                end else begin
                    bq.push_back(s);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (clr) m_cnt[k] = inc[k] ? 1 : 0;
            else if (inc[k] && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic fs, input logic clr);
        sin_valid   = v;
        sin         = s;
        frame_start = fs;
        clear_cnt   = clr;
        @(posedge clk);
        model_update(v, s, fs, clr);
        #1;
        check_all();
    endtask

    task automatic gap_cycles(input int n);
        for (int g = 0; g < n; g++) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] word, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, word[i], (i == 0), 1'b0);
            gap_cycles(gap);
        end
    endtask

    task automatic send_frame(input logic [7:0] word, input logic par, input int gap, input logic clr);
        send_bits(word, 8, gap);
        step(1'b1, par, 1'b0, clr);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        sin = 0; sin_valid = 0; frame_start = 0; clear_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // good and bad parity on 0xA5
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        // gapped frame
        send_frame(8'h3C, 1'b0, 3, 1'b0);
        // abort after four bits, restart with 0xFF
        send_bits(8'h5A, 4, 0);
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        // start coinciding with the parity bit
        send_bits(8'h12, 8, 0);
        send_frame(8'h34, 1'b1, 0, 1'b0);
        // saturation on the narrow counter
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'h00, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // async reset mid-frame
        send_bits(8'hC3, 3, 0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_frame(8'h81, 1'b0, 0, 1'b0);

        // randomized frames and free-running bits
        for (int r = 0; r < 60; r++) begin
            send_frame(8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                       ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), int'($urandom_range(1, 8)), 0);
        end
        for (int r = 0; r < 600; r++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Receive end of the team's serial parity link. Accepts a framed serial stream: DATA_W data bits sent LSB first, then one parity bit. Reassembles the data word, checks parity with a running XOR accumulator, and counts parity errors in a saturating counter. Sits downstream of the XOR-based parity generator/serialiser and feeds word-level logic.

Parameters:
DATA_W, 8, data bits per frame (>=2)
ODD_PARITY, 0, 0 = even parity (XOR of data+parity must be 0); 1 = odd parity (must be 1)
ERR_CNT_W, 8, width of the saturating parity-error counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
sin  input  1  serial bit
sin_valid  input  1  sin is a real bit this cycle; low = gap, all state held
frame_start  input  1  qualified by sin_valid; marks the first data bit of a frame
clear_cnt  input  1  synchronous clear of err_count
data_out  output  DATA_W  last completed word, held until the next completion
frame_done  output  1  one-cycle pulse: frame completed
parity_err  output  1  parity result of the last frame, held until the next completion
frame_abort  output  1  one-cycle pulse: frame_start arrived mid-frame
err_count  output  ERR_CNT_W  saturating count of parity errors

Behaviour:
- Reset (async, active-high): state=IDLE, bit index=0, accumulator=0, shift reg=0. All outputs 0.
- Only cycles with sin_valid=1 advance anything. frame_start with sin_valid=0 is ignored.
- States:
  - IDLE: sin_valid&frame_start -> load sin as bit 0, acc=sin, idx=1, go to DATA. Bits with frame_start=0 are discarded.
  - DATA: each valid bit is stored at position idx, acc^=sin, idx++. After bit DATA_W-1 is stored, go to PARITY.
  - PARITY: the next valid bit is the parity bit.
    - On that edge: data_out<=assembled word; parity_err<=(acc^sin)!=ODD_PARITY; frame_done<=1.
    - Go to IDLE.
- Latency: frame_done, data_out and parity_err are visible the cycle after the parity bit is accepted.
- frame_done and frame_abort are single-cycle pulses; otherwise 0.
- frame_start&sin_valid while in DATA or PARITY:
  - The current frame is dropped: no frame_done, no counter change.
  - frame_abort pulses.
  - The bit is taken as bit 0 of a new frame, state=DATA.
- frame_start coinciding with the parity bit in PARITY is treated as an abort (start wins). The parity bit is not checked.
- err_count:
  - Increments on each completed frame with parity_err=1.
  - Saturates at 2^ERR_CNT_W-1; never wraps.
  - clear_cnt alone -> 0.
  - clear_cnt in the same cycle as an increment -> 1.
- Reset mid-frame: partial frame discarded, no pulses, all outputs return to 0.
- Accumulator and shift register are internal only; they are not visible on outputs between frames.

Decomposition:
- Package parity_pkg:
  - state typedef enum {IDLE, DATA, PARITY}
  - constants PARITY_EVEN=0, PARITY_ODD=1
- Sub-module sat_counter (parameter W; inputs inc, clr; output count). It implements the err_count saturation and the clear/increment priority, so it can be reused and verified standalone.
- The XOR accumulator stays inline; it is one flop and one gate.

Test Plan:
1. DATA_W=8, even. frame_start with bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0 -> next cycle frame_done=1, data_out=0xA5, parity_err=0, err_count=0.
2. Same frame, parity bit 1 -> parity_err=1, err_count=1. Repeat with ODD_PARITY=1 and parity 1 -> parity_err=0.
3. Frame 0x3C with sin_valid low for 3 cycles between each bit -> identical result to back-to-back: data_out=0x3C, done pulses exactly once.
4. Abort: send 4 bits of a frame, then frame_start with new frame 0xFF, parity 0 -> frame_abort pulses once, then frame_done with data_out=0xFF, parity_err=0, err_count unchanged.
5. ERR_CNT_W=2. Five bad-parity frames -> err_count 1,2,3,3,3. Then clear_cnt coinciding with a sixth bad completion -> err_count=1. Then clear_cnt alone -> 0.
6. Assert reset asynchronously (between edges) mid-DATA -> all outputs 0 immediately. Next full valid frame 0x81 with parity 0 -> checks cleanly, data_out=0x81, parity_err=0.
